// File: rtl/order_pkg.sv
// Shared definitions for the order path: word width, packed order field
// layout, and pack/unpack helpers used by the queue and the control FSM.
package order_pkg;

    localparam int ORDER_W = 256;

    localparam int OP_OFF = 0;
    localparam int OP_W = 3;
    localparam int FBASE_OFF = 3;
    localparam int FBASE_W = 32;
    localparam int PATCH_OFF = 35;
    localparam int PATCH_W = 16;
    localparam int ROW_OFF = 51;
    localparam int ROW_W = 16;
    localparam int COL_OFF = 67;
    localparam int COL_W = 16;
    localparam int QIN_OFF = 83;
    localparam int QIN_W = 8;
    localparam int QWT_OFF = 91;
    localparam int QWT_W = 8;
    localparam int QOUT_OFF = 99;
    localparam int QOUT_W = 8;
    localparam int STRIDE_OFF = 107;
    localparam int STRIDE_W = 4;
    localparam int RET_OFF = 111;
    localparam int RET_W = 32;
    localparam int PAD_OFF = 143;
    localparam int PAD_W = 4;
    localparam int WLEN_OFF = 147;
    localparam int WLEN_W = 32;
    localparam int ACT_OFF = 179;
    localparam int ACT_W = 1;
    localparam int ID_OFF = 180;
    localparam int ID_W = 16;

    typedef struct packed {
        logic [ID_W-1:0]     id;
        logic [ACT_W-1:0]    activate;
        logic [WLEN_W-1:0]   weight_len;
        logic [PAD_W-1:0]    padding;
        logic [RET_W-1:0]    return_addr;
        logic [STRIDE_W-1:0] stride;
        logic [QOUT_W-1:0]   quant_out;
        logic [QWT_W-1:0]    quant_wt;
        logic [QIN_W-1:0]    quant_in;
        logic [COL_W-1:0]    col_size;
        logic [ROW_W-1:0]    row_size;
        logic [PATCH_W-1:0]  patch_cnt;
        logic [FBASE_W-1:0]  feat_base;
        logic [OP_W-1:0]     op;
    } order_t;

    function automatic logic [ORDER_W-1:0] order_pack(input order_t o);
        logic [ORDER_W-1:0] w;
        w = '0;
        w[OP_OFF +: OP_W] = o.op;
        w[FBASE_OFF +: FBASE_W] = o.feat_base;
        w[PATCH_OFF +: PATCH_W] = o.patch_cnt;
        w[ROW_OFF +: ROW_W] = o.row_size;
        w[COL_OFF +: COL_W] = o.col_size;
        w[QIN_OFF +: QIN_W] = o.quant_in;
        w[QWT_OFF +: QWT_W] = o.quant_wt;
        w[QOUT_OFF +: QOUT_W] = o.quant_out;
        w[STRIDE_OFF +: STRIDE_W] = o.stride;
        w[RET_OFF +: RET_W] = o.return_addr;
        w[PAD_OFF +: PAD_W] = o.padding;
        w[WLEN_OFF +: WLEN_W] = o.weight_len;
        w[ACT_OFF +: ACT_W] = o.activate;
        w[ID_OFF +: ID_W] = o.id;
        return w;
    endfunction

    function automatic order_t order_unpack(input logic [ORDER_W-1:0] w);
        order_t o;
        o.op = w[OP_OFF +: OP_W];
        o.feat_base = w[FBASE_OFF +: FBASE_W];
        o.patch_cnt = w[PATCH_OFF +: PATCH_W];
        o.row_size = w[ROW_OFF +: ROW_W];
        o.col_size = w[COL_OFF +: COL_W];
        o.quant_in = w[QIN_OFF +: QIN_W];
        o.quant_wt = w[QWT_OFF +: QWT_W];
        o.quant_out = w[QOUT_OFF +: QOUT_W];
        o.stride = w[STRIDE_OFF +: STRIDE_W];
        o.return_addr = w[RET_OFF +: RET_W];
        o.padding = w[PAD_OFF +: PAD_W];
        o.weight_len = w[WLEN_OFF +: WLEN_W];
        o.activate = w[ACT_OFF +: ACT_W];
        o.id = w[ID_OFF +: ID_W];
        return o;
    endfunction

endpackage

// File: rtl/order_queue_ram.sv
// Body storage for order_queue: DEPTH x W, one write port, one registered
// read port. Ports: clk, we_i/waddr_i/wdata_i, raddr_i, rdata_o. No reset.
module order_queue_ram #(
    parameter int W     = 256,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Write-first: a word written to the address being read is returned
    // immediately, so the head can reload from a slot filled last cycle.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_q <= wdata_i;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/order_queue.sv
// FWFT order queue: registered head stage fed from a RAM body or directly
// from push when the body is empty. Ports: valid/ready push and pop sides,
// flush, fill level, almost_full, empty and a wrapping pop counter.
module order_queue #(
    parameter int ORDER_W     = order_pkg::ORDER_W,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [ORDER_W-1:0]       push_data,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [ORDER_W-1:0]       pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     empty,
    output logic [31:0]              issue_cnt
);

    import order_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_LEVEL);

    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic [LW-1:0]      body_cnt;
    logic               head_vld_q, head_vld_d;
    logic [ORDER_W-1:0] head_q, head_d;
    logic [31:0]        issue_q, issue_d;
    logic [ORDER_W-1:0] ram_rdata;
    logic               push_fire, pop_fire;
    logic               head_free, body_nz;
    logic               load_body, load_push, ram_we;

    assign push_ready = (level_q != FULL_LVL);

    always_comb begin
        push_fire = push_valid & push_ready;
        pop_fire  = head_vld_q & pop_ready;
        // Body holds every word except the one in the head register.
        body_cnt  = level_q - LW'(head_vld_q);
        body_nz   = (body_cnt != '0);
        head_free = ~head_vld_q | pop_fire;
        load_body = ~flush & head_free & body_nz;
        // Empty body: the pushed word skips the RAM and lands in the head.
        load_push = ~flush & head_free & ~body_nz & push_fire;
        ram_we    = ~flush & push_fire & ~load_push;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(ram_we);
        rd_ptr_d   = rd_ptr_q + AW'(load_body);
        head_d     = head_q;
        head_vld_d = head_vld_q;
        level_d    = level_q;
        issue_d    = issue_q;
        if (load_body) begin
            head_d = ram_rdata;
        end else if (load_push) begin
            head_d = push_data;
        end
        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            head_vld_d = 1'b0;
            level_d    = '0;
        end else begin
            if (load_body || load_push) begin
                head_vld_d = 1'b1;
            end else if (pop_fire) begin
                head_vld_d = 1'b0;
            end
            if (push_fire && !pop_fire) begin
                level_d = level_q + LW'(1);
            end else if (pop_fire && !push_fire) begin
                level_d = level_q - LW'(1);
            end
            issue_d = issue_q + 32'(pop_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            head_vld_q <= 1'b0;
            head_q     <= '0;
            issue_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
            issue_q    <= issue_d;
        end
    end

    // Read address tracks the next pointer so the RAM output always shows
    // the oldest body word during the cycle it may be needed.
    order_queue_ram #(
        .W     (ORDER_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (push_data),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

    assign pop_valid   = head_vld_q;
    assign pop_data    = head_q;
    assign level       = level_q;
    assign almost_full = (level_q >= AFULL_LVL);
    assign empty       = (level_q == '0);
    assign issue_cnt   = issue_q;

endmodule

// File: tb/tb_order_queue.sv
// Scoreboard bench for order_queue: driver issues directed and random
// traffic, monitor compares DUT outputs against a queue-based model.
module tb_order_queue;

    import order_pkg::*;

    localparam int DEPTH = 4;
    localparam int AFL   = 3;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               flush = 1'b0;
    logic               push_valid = 1'b0;
    logic               push_ready;
    logic [ORDER_W-1:0] push_data = '0;
    logic               pop_valid;
    logic               pop_ready = 1'b0;
    logic [ORDER_W-1:0] pop_data;
    logic [LW-1:0]      level;
    logic               almost_full;
    logic               empty;
    logic [31:0]        issue_cnt;

    logic [ORDER_W-1:0] sbq[$];
    bit                 pend_push = 1'b0;
    bit                 do_force = 1'b0;
    logic [31:0]        exp_issue = '0;
    int                 vectors = 0;
    int                 miscompares = 0;
    int unsigned        seq = 0;

    order_queue #(
        .ORDER_W     (ORDER_W),
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_data   (push_data),
        .pop_valid   (pop_valid),
        .pop_ready   (pop_ready),
        .pop_data    (pop_data),
        .level       (level),
        .almost_full (almost_full),
        .empty       (empty),
        .issue_cnt   (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [ORDER_W-1:0] act,
                       input logic [ORDER_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [ORDER_W-1:0] mk_word(input int unsigned n);
        order_t o;
        o.op = 3'($urandom);
        o.feat_base = $urandom;
        o.patch_cnt = 16'($urandom);
        o.row_size = 16'($urandom);
        o.col_size = 16'($urandom);
        o.quant_in = 8'($urandom);
        o.quant_wt = 8'($urandom);
        o.quant_out = 8'($urandom);
        o.stride = 4'($urandom);
        o.return_addr = $urandom;
        o.padding = 4'($urandom);
        o.weight_len = $urandom;
        o.activate = 1'($urandom);
        o.id = 16'(n);
        return order_pack(o);
    endfunction

    // One cycle of stimulus, applied shortly after the rising edge.
    // An accepted push is appended to the scoreboard right away and
    // flagged pending until the monitor has checked this cycle.
    task automatic cyc(input bit pv, input bit pr, input bit fl);
        logic [ORDER_W-1:0] w;
        @(posedge clk);
        #2;
        w = mk_word(seq);
        seq++;
        push_valid = pv;
        pop_ready  = pr;
        flush      = fl;
        push_data  = w;
        pend_push  = 1'b0;
        if (rst_n && pv && !fl && (sbq.size() != DEPTH)) begin
            sbq.push_back(w);
            pend_push = 1'b1;
        end
    endtask

    // Monitor: compare on the falling edge, then retire this cycle's pop.
    initial begin
        int el;
        forever begin
            @(negedge clk);
            el = sbq.size() - int'(pend_push);
            if (!rst_n) begin
                exp_issue = '0;
                chk("rst_pop_data", pop_data, '0);
            end
            if (do_force) exp_issue = 32'hFFFF_FFFF;
            chk("level", ORDER_W'(level), ORDER_W'(el));
            chk("push_ready", ORDER_W'(push_ready), ORDER_W'(el != DEPTH));
            chk("empty", ORDER_W'(empty), ORDER_W'(el == 0));
            chk("almost_full", ORDER_W'(almost_full), ORDER_W'(el >= AFL));
            chk("pop_valid", ORDER_W'(pop_valid), ORDER_W'(el != 0));
            chk("issue_cnt", ORDER_W'(issue_cnt), ORDER_W'(exp_issue));
            if (el > 0) chk("pop_data", pop_data, sbq[0]);
            if (rst_n) begin
                if (flush) begin
                    sbq.delete();
                end else if (el > 0 && pop_ready) begin
                    void'(sbq.pop_front());
                    exp_issue = exp_issue + 32'd1;
                end
            end
        end
    end

    initial begin
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // fill to full, then one extra push held off
        repeat (5) cyc(1, 0, 0);
        // drain from full
        repeat (4) cyc(0, 1, 0);
        cyc(0, 0, 0);

        // steady push+pop at level 2
        repeat (2) cyc(1, 0, 0);
        repeat (10) cyc(1, 1, 0);

        // level 3 then flush with a push offered
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);

        // issue counter wrap
        @(posedge clk);
        #2;
        force dut.issue_q = 32'hFFFF_FFFF;
        do_force = 1'b1;
        pend_push = 1'b0;
        push_valid = 1'b0;
        pop_ready = 1'b0;
        cyc(0, 0, 0);
        release dut.issue_q;
        do_force = 1'b0;
        cyc(0, 1, 0);
        cyc(0, 0, 0);

        // async reset with three words queued
        repeat (3) cyc(1, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push_valid = 1'b0;
        pop_ready = 1'b0;
        flush = 1'b0;
        pend_push = 1'b0;
        sbq.delete();
        #1;
        chk("async_rst_level", ORDER_W'(level), '0);
        chk("async_rst_pop_valid", ORDER_W'(pop_valid), '0);
        cyc(0, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        push_data = mk_word(seq);
        seq++;
        push_valid = 1'b1;
        sbq.push_back(push_data);
        pend_push = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(99) < 65, $urandom_range(99) < 55,
                $urandom_range(99) < 3);
        end
        cyc(0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
